// File: rtl/rx_ctrl.sv
// UART receive control: synchronises SDI, validates start bits, times bits from a baud table.
// Latency: start rises 1 cycle after the sdi_sync falling edge; done comes 1 cycle after the final btu.
// Backpressure: none; the strobes are free-running and the datapath must accept them as issued.
//
// Ports:
//   clk      - system clock (100 MHz)
//   reset_n  - asynchronous active-low reset
//   SDI      - raw serial input, idles high
//   baud     - baud select (0..15), latched at frame start
//   bit8     - 1 = 8 data bits, 0 = 7; latched at frame start
//   pen      - parity enable; latched at frame start
//   sdi_sync - synchronised SDI for the datapath
//   btu      - 1-cycle pulse at the middle of each sampled bit
//   start    - high while the start bit is being validated
//   done     - 1-cycle pulse when the frame is complete
module rx_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 19
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       SDI,
  input  logic [3:0] baud,
  input  logic       bit8,
  input  logic       pen,
  output logic       sdi_sync,
  output logic       btu,
  output logic       start,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               sdi_prev_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         bitcnt_q, bitcnt_d;
  logic [3:0]         baud_q;
  logic               bit8_q, pen_q;
  logic               cfg_load;

  logic [CNT_W-1:0]   k_val;
  logic [CNT_W-1:0]   half_m1;
  logic [CNT_W-1:0]   k_m1;
  logic [3:0]         nbits;
  logic               fall_edge;
  logic               half_hit;
  logic               full_hit;

  // Synchroniser chain plus one extra flop for falling-edge detection.
  // Everything resets to the idle-high line level so reset release never
  // looks like a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '1;
      sdi_prev_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], SDI};
      sdi_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sdi_sync  = sync_q[SYNC_STAGES-1];
  // Edge needs a high-then-low history, so a line stuck low cannot re-arm.
  assign fall_edge = sdi_prev_q & ~sdi_sync;

  // Clocks per bit for the frame's latched baud select.
  always_comb begin
    k_val = CNT_W'(109);
    case (baud_q)
      4'd0:    k_val = CNT_W'(333333);
      4'd1:    k_val = CNT_W'(83333);
      4'd2:    k_val = CNT_W'(41667);
      4'd3:    k_val = CNT_W'(20833);
      4'd4:    k_val = CNT_W'(10417);
      4'd5:    k_val = CNT_W'(5208);
      4'd6:    k_val = CNT_W'(2604);
      4'd7:    k_val = CNT_W'(1736);
      4'd8:    k_val = CNT_W'(868);
      4'd9:    k_val = CNT_W'(434);
      4'd10:   k_val = CNT_W'(217);
      default: k_val = CNT_W'(109);
    endcase
  end

  assign half_m1  = (k_val >> 1) - CNT_W'(1);
  assign k_m1     = k_val - CNT_W'(1);
  // Shifting btus per frame: data bits, optional parity, stop bit.
  assign nbits    = 4'd8 + {3'b000, bit8_q} + {3'b000, pen_q};
  assign half_hit = (cnt_q == half_m1);
  assign full_hit = (cnt_q == k_m1);

  // State register, counters and frame configuration.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      baud_q   <= '0;
      bit8_q   <= 1'b0;
      pen_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      if (cfg_load) begin
        baud_q <= baud;
        bit8_q <= bit8;
        pen_q  <= pen;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    cfg_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall_edge) begin
          state_d  = ST_START;
          cnt_d    = '0;
          bitcnt_d = '0;
          cfg_load = 1'b1;
        end
      end
      ST_START: begin
        if (half_hit) begin
          cnt_d    = '0;
          bitcnt_d = '0;
          // Line back high at mid start bit means a glitch, not a frame.
          state_d  = sdi_sync ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (full_hit) begin
          cnt_d    = '0;
          bitcnt_d = bitcnt_q + 4'd1;
          if ((bitcnt_q + 4'd1) == nbits) begin
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic. btu stays combinational so the start-bit btu is seen
  // together with start=1 and the datapath does not shift on it.
  always_comb begin
    start = 1'b0;
    done  = 1'b0;
    btu   = 1'b0;
    case (state_q)
      ST_START: begin
        start = 1'b1;
        btu   = half_hit;
      end
      ST_DATA: begin
        btu = full_hit;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        start = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rx_ctrl.sv
`timescale 1ns/1ps
module tb_rx_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       SDI = 1'b1;
  logic [3:0] baud = 4'd11;
  logic       bit8 = 1'b0;
  logic       pen = 1'b0;
  logic       sdi_sync;
  logic       btu;
  logic       start;
  logic       done;

  int vectors = 0;
  int miscompares = 0;

  rx_ctrl #(.SYNC_STAGES(2), .CNT_W(19)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .SDI      (SDI),
    .baud     (baud),
    .bit8     (bit8),
    .pen      (pen),
    .sdi_sync (sdi_sync),
    .btu      (btu),
    .start    (start),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Event monitor: cycle stamps of btus/done and a tiny datapath that
  // captures sdi_sync on every shifting btu (btu & ~start).
  int         cyc = 0;
  int         st_t = 0;
  int         start_rises = 0;
  int         overlap = 0;
  logic       start_prev = 1'b0;
  logic [15:0] cap = '0;
  logic [3:0] ncap = '0;
  int         sbtu_t[$];
  int         dbtu_t[$];
  int         done_t[$];

  always @(negedge clk) begin
    cyc        <= cyc + 1;
    start_prev <= start;
    if (start && !start_prev) begin
      st_t        <= cyc;
      start_rises <= start_rises + 1;
      ncap        <= '0;
    end
    if (btu && start) sbtu_t.push_back(cyc);
    if (btu && !start) begin
      dbtu_t.push_back(cyc);
      cap[ncap] <= sdi_sync;
      ncap      <= ncap + 4'd1;
    end
    if (done) done_t.push_back(cyc);
    if (btu && done) overlap <= overlap + 1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Start bit, then bits[0..nbits-1] LSB first (data, parity, stop), k cycles each.
  task automatic send_frame(input int k, input logic [11:0] bits, input int nbits);
    logic [11:0] b;
    b = bits;
    SDI = 1'b0;
    step(k);
    for (int i = 0; i < nbits; i++) begin
      SDI = b[i];
      step(k);
    end
    SDI = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    SDI = 1'b1;
    step(3);
    vectors++; if (sdi_sync !== 1'b1) begin miscompares++; $display("FAIL reset_sdi_sync got=%b exp=1", sdi_sync); end
    vectors++; if (btu !== 1'b0) begin miscompares++; $display("FAIL reset_btu got=%b exp=0", btu); end
    vectors++; if (start !== 1'b0) begin miscompares++; $display("FAIL reset_start got=%b exp=0", start); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
    reset_n = 1'b1;
    step(10);
    vectors++; if (start_rises !== 0) begin miscompares++; $display("FAIL reset_no_arm got=%0d exp=0", start_rises); end
  endtask

  task automatic test_reset_midframe();
    int bd, bb, bs;
    bit seen;
    baud = 4'd11; bit8 = 1'b1; pen = 1'b0;
    bd = done_t.size();
    bb = dbtu_t.size();
    seen = 0;
    SDI = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      step(1);
      if (dbtu_t.size() - bb == 4) seen = 1;
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL midframe_reach_bit4 got=%0d btus exp=4", dbtu_t.size() - bb); end
    step(20);
    reset_n = 1'b0;
    #1;
    vectors++; if (start !== 1'b0 || btu !== 1'b0 || done !== 1'b0 || sdi_sync !== 1'b1)
      begin miscompares++; $display("FAIL midframe_reset_idle got=%b%b%b%b exp=0001", start, btu, done, sdi_sync); end
    SDI = 1'b1;
    step(3);
    reset_n = 1'b1;
    step(1500);
    vectors++; if (done_t.size() !== bd) begin miscompares++; $display("FAIL midframe_no_done got=%0d exp=%0d", done_t.size(), bd); end
    bd = done_t.size();
    bb = dbtu_t.size();
    bs = start_rises;
    send_frame(109, {3'b000, 1'b1, 8'h3C}, 9);
    step(200);
    vectors++; if (dbtu_t.size() - bb !== 9) begin miscompares++; $display("FAIL post_reset_btus got=%0d exp=9", dbtu_t.size() - bb); end
    vectors++; if (done_t.size() - bd !== 1) begin miscompares++; $display("FAIL post_reset_done got=%0d exp=1", done_t.size() - bd); end
    vectors++; if (cap[8:0] !== 9'h13C) begin miscompares++; $display("FAIL post_reset_data got=%h exp=13c", cap[8:0]); end
    vectors++; if (start_rises - bs !== 1) begin miscompares++; $display("FAIL post_reset_starts got=%0d exp=1", start_rises - bs); end
  endtask

  // 8 data + parity + stop at k=868 (half=434).
  task automatic test_frame_8p();
    int bs, bb, bd, t0, last;
    baud = 4'd8; bit8 = 1'b1; pen = 1'b1;
    bs = sbtu_t.size(); bb = dbtu_t.size(); bd = done_t.size();
    send_frame(868, {2'b00, 1'b1, 1'b0, 8'hA5}, 10);
    step(100);
    vectors++; if (sbtu_t.size() - bs !== 1) begin miscompares++; $display("FAIL f8_start_btus got=%0d exp=1", sbtu_t.size() - bs); end
    vectors++; if (dbtu_t.size() - bb !== 10) begin miscompares++; $display("FAIL f8_data_btus got=%0d exp=10", dbtu_t.size() - bb); end
    vectors++; if (done_t.size() - bd !== 1) begin miscompares++; $display("FAIL f8_done_count got=%0d exp=1", done_t.size() - bd); end
    if (sbtu_t.size() - bs == 1 && dbtu_t.size() - bb == 10 && done_t.size() - bd == 1) begin
      // START entry is taken as the arming cycle, one before start rises.
      t0 = st_t - 1;
      vectors++; if (sbtu_t[bs] - t0 !== 434) begin miscompares++; $display("FAIL f8_start_btu_time got=%0d exp=434", sbtu_t[bs] - t0); end
      vectors++; if (dbtu_t[bb] - t0 !== 434 + 868) begin miscompares++; $display("FAIL f8_first_btu_time got=%0d exp=1302", dbtu_t[bb] - t0); end
      for (int i = 1; i < 10; i++) begin
        vectors++;
        if (dbtu_t[bb+i] - dbtu_t[bb+i-1] !== 868) begin
          miscompares++; $display("FAIL f8_gap%0d got=%0d exp=868", i, dbtu_t[bb+i] - dbtu_t[bb+i-1]);
        end
      end
      last = dbtu_t[bb+9];
      vectors++; if (done_t[bd] - last !== 1) begin miscompares++; $display("FAIL f8_done_time got=%0d exp=1", done_t[bd] - last); end
    end
    vectors++; if (cap[9:0] !== 10'h2A5) begin miscompares++; $display("FAIL f8_data got=%h exp=2a5", cap[9:0]); end
    vectors++; if (overlap !== 0) begin miscompares++; $display("FAIL f8_btu_done_overlap got=%0d exp=0", overlap); end
  endtask

  // 7 data, no parity, k=109 (half=54).
  task automatic test_frame_7n();
    int bs, bb, bd;
    baud = 4'd11; bit8 = 1'b0; pen = 1'b0;
    bs = sbtu_t.size(); bb = dbtu_t.size(); bd = done_t.size();
    send_frame(109, {4'b0000, 1'b1, 7'h5A}, 8);
    step(200);
    vectors++; if (dbtu_t.size() - bb !== 8) begin miscompares++; $display("FAIL f7_data_btus got=%0d exp=8", dbtu_t.size() - bb); end
    vectors++; if (done_t.size() - bd !== 1) begin miscompares++; $display("FAIL f7_done_count got=%0d exp=1", done_t.size() - bd); end
    vectors++; if (cap[7:0] !== 8'hDA) begin miscompares++; $display("FAIL f7_data got=%h exp=da", cap[7:0]); end
    if (sbtu_t.size() - bs == 1 && dbtu_t.size() - bb == 8) begin
      vectors++; if (sbtu_t[bs] - (st_t - 1) !== 54) begin miscompares++; $display("FAIL f7_start_btu_time got=%0d exp=54", sbtu_t[bs] - (st_t - 1)); end
      vectors++; if (dbtu_t[bb] - (st_t - 1) !== 163) begin miscompares++; $display("FAIL f7_first_btu_time got=%0d exp=163", dbtu_t[bb] - (st_t - 1)); end
    end
  endtask

  task automatic test_false_start();
    int bs, bb, bd;
    baud = 4'd4; bit8 = 1'b1; pen = 1'b1;
    bs = sbtu_t.size(); bb = dbtu_t.size(); bd = done_t.size();
    SDI = 1'b0;
    step(1000);
    SDI = 1'b1;
    step(11000);
    vectors++; if (sbtu_t.size() - bs !== 1) begin miscompares++; $display("FAIL fs_start_btus got=%0d exp=1", sbtu_t.size() - bs); end
    vectors++; if (dbtu_t.size() - bb !== 0) begin miscompares++; $display("FAIL fs_data_btus got=%0d exp=0", dbtu_t.size() - bb); end
    vectors++; if (done_t.size() - bd !== 0) begin miscompares++; $display("FAIL fs_done got=%0d exp=0", done_t.size() - bd); end
    vectors++; if (start !== 1'b0) begin miscompares++; $display("FAIL fs_start_idle got=%b exp=0", start); end
    if (sbtu_t.size() - bs == 1) begin
      vectors++; if (sbtu_t[bs] - (st_t - 1) !== 5208) begin miscompares++; $display("FAIL fs_btu_time got=%0d exp=5208", sbtu_t[bs] - (st_t - 1)); end
    end
  endtask

  task automatic test_framing_error();
    int bd, bs;
    baud = 4'd11; bit8 = 1'b1; pen = 1'b0;
    bd = done_t.size(); bs = start_rises;
    SDI = 1'b0;
    step(109 * 12 + 2000);
    vectors++; if (done_t.size() - bd !== 1) begin miscompares++; $display("FAIL ferr_done got=%0d exp=1", done_t.size() - bd); end
    vectors++; if (start_rises - bs !== 1) begin miscompares++; $display("FAIL ferr_no_rearm got=%0d exp=1", start_rises - bs); end
    vectors++; if (cap[8] !== 1'b0) begin miscompares++; $display("FAIL ferr_stop_bit got=%b exp=0", cap[8]); end
    SDI = 1'b1;
    step(50);
    SDI = 1'b0;
    step(20);
    vectors++; if (start !== 1'b1) begin miscompares++; $display("FAIL ferr_rearm_start got=%b exp=1", start); end
    SDI = 1'b1;
    step(200);
    vectors++; if (done_t.size() - bd !== 1) begin miscompares++; $display("FAIL ferr_glitch_done got=%0d exp=1", done_t.size() - bd); end
  endtask

  task automatic test_back_to_back();
    int bd, bb, bs;
    bit seen;
    logic [6:0] d1;
    baud = 4'd11; bit8 = 1'b0; pen = 1'b0;
    bd = done_t.size(); bb = dbtu_t.size(); bs = start_rises;
    d1 = 7'h33;
    SDI = 1'b0;
    step(109);
    for (int i = 0; i < 7; i++) begin
      SDI = d1[i];
      step(109);
    end
    SDI = 1'b1;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (dbtu_t.size() - bb == 8) seen = 1;
      else step(1);
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL b2b_stop_btu got=%0d exp=8", dbtu_t.size() - bb); end
    // Fall now so sdi_sync drops exactly in the first IDLE cycle after DONE.
    SDI = 1'b0;
    step(3);
    vectors++; if (start !== 1'b1) begin miscompares++; $display("FAIL b2b_accept got=%b exp=1", start); end
    vectors++; if (done_t.size() - bd !== 1) begin miscompares++; $display("FAIL b2b_first_done got=%0d exp=1", done_t.size() - bd); end
    step(106);
    d1 = 7'h4C;
    for (int i = 0; i < 7; i++) begin
      SDI = d1[i];
      step(109);
    end
    SDI = 1'b1;
    step(300);
    vectors++; if (done_t.size() - bd !== 2) begin miscompares++; $display("FAIL b2b_second_done got=%0d exp=2", done_t.size() - bd); end
    vectors++; if (dbtu_t.size() - bb !== 16) begin miscompares++; $display("FAIL b2b_btus got=%0d exp=16", dbtu_t.size() - bb); end
    vectors++; if (cap[7:0] !== 8'hCC) begin miscompares++; $display("FAIL b2b_data got=%h exp=cc", cap[7:0]); end
    vectors++; if (start_rises - bs !== 2) begin miscompares++; $display("FAIL b2b_starts got=%0d exp=2", start_rises - bs); end
  endtask

  task automatic test_config_change();
    int bd, bb;
    baud = 4'd11; bit8 = 1'b1; pen = 1'b0;
    bd = done_t.size(); bb = dbtu_t.size();
    fork
      send_frame(109, {3'b000, 1'b1, 8'h96}, 9);
      begin
        step(400);
        pen = 1'b1;
        baud = 4'd4;
      end
    join
    step(200);
    vectors++; if (dbtu_t.size() - bb !== 9) begin miscompares++; $display("FAIL cfg_btus got=%0d exp=9", dbtu_t.size() - bb); end
    vectors++; if (done_t.size() - bd !== 1) begin miscompares++; $display("FAIL cfg_done got=%0d exp=1", done_t.size() - bd); end
    if (dbtu_t.size() - bb == 9) begin
      vectors++; if (dbtu_t[bb+8] - dbtu_t[bb] !== 872) begin miscompares++; $display("FAIL cfg_span got=%0d exp=872", dbtu_t[bb+8] - dbtu_t[bb]); end
    end
    baud = 4'd11;
    bd = done_t.size(); bb = dbtu_t.size();
    send_frame(109, {2'b00, 1'b1, 1'b0, 8'h96}, 10);
    step(200);
    vectors++; if (dbtu_t.size() - bb !== 10) begin miscompares++; $display("FAIL cfg_next_btus got=%0d exp=10", dbtu_t.size() - bb); end
    vectors++; if (done_t.size() - bd !== 1) begin miscompares++; $display("FAIL cfg_next_done got=%0d exp=1", done_t.size() - bd); end
    vectors++; if (cap[9:0] !== 10'h296) begin miscompares++; $display("FAIL cfg_next_data got=%h exp=296", cap[9:0]); end
  endtask

  initial begin
    test_reset();
    test_reset_midframe();
    test_frame_8p();
    test_frame_7n();
    test_false_start();
    test_framing_error();
    test_back_to_back();
    test_config_change();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
